shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter. It succeeds the fixed 32-bit combinational logical-left shifter and adds:
- logical right, arithmetic right and optional rotate operations;
- a registered stage per shift-amount bit;
- a valid/ready handshake with backpressure, and a flush.

It sits between operand issue and ALU writeback, where a shift needs a full clock period per log2 stage.

## Interface
- N, default 32: data width. Must be a power of two and at least 8.
- L, default $clog2(N): derived stage count and latency. Do not override.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  discards all in-flight operations.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  N  operand.
- in_shamt  in  L  shift amount, 0..N-1, unsigned.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  N  result.
- out_illegal  out  1  result came from an unsupported op; qualified by out_valid.

## Operation
- Pipeline has L stages, numbered 0..L-1. Each stage register holds: valid, data, op, shamt.
- Stage k shifts its data by 2^k when shamt[k]=1; otherwise it passes the data through. Stage 0 applies shamt[0].
- Fill per op:
  - SLL: zeros in at the LSB.
  - SRL: zeros in at the MSB.
  - SRA: copies of the original operand bit N-1 in at the MSB. Each stage takes its fill from the current data MSB, which equals the original sign.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Input is accepted when in_valid && in_ready. It is captured in stage 0 already shifted by shamt[0].
- The final stage register drives out_data and out_valid.
- Global stall: stall = out_valid && !out_ready. While stall is high, every stage register holds its value.
- in_ready = !stall. The pipeline therefore advances only as a whole.
- Bubbles are preserved: a stage with valid=0 still advances.
- shamt=0 returns in_data unchanged for every supported op.
- flush (when rst is high): all stage valid bits clear on the next edge.
  - Flush overrides stall.
  - An input accepted in the same cycle is discarded; in_ready is not gated by flush.
  - Data registers need not clear.
- Simultaneous flush and out_ready: the output counts as consumed, then cleared.
- Reset (rst low at an edge):
  - all valid bits are 0 and out_data is 0 on the next cycle;
  - out_illegal is 0 and in_ready is 1;
  - reset wins over flush and stall;
  - a reset mid-stream loses all in-flight operations.

## Timing
- Latency: an input accepted at edge t appears with out_valid=1 after edge t+L-1, i.e. L cycles of pipeline registers. N=32 gives L=5.
- Throughput: one operation per cycle when out_ready is held high.
- Results leave in input order. Each held output stays stable until accepted.
- in_ready depends combinationally on out_ready. This is the only combinational in-to-out path.
- out_data, out_valid and out_illegal are registered outputs.

## Configuration
- SHIFT_PIPE_ROTATE_EN defined:
  - op 11 performs rotate-right by shamt;
  - out_illegal is always 0.
- SHIFT_PIPE_ROTATE_EN undefined:
  - no rotate logic is built;
  - op 11 produces out_data = 0 with out_illegal = 1, at the same latency and with the same handshake;
  - ops 00–10 are unaffected.

## Test plan
- SLL, N=32: in_data 0x0000_0001, shamt 31 -> out_data 0x8000_0000, out_valid rises 5 cycles after accept. Also shamt 0 -> 0x0000_0001.
- SRA and SRL: in_data 0x8000_00F0, shamt 4 -> SRA 0xF800_000F, SRL 0x0800_000F. SRA of 0x7FFF_FFFF by 31 -> 0x0000_0000.
- ROR: in_data 0x0000_00F1, shamt 4.
  - With macro: 0x1000_000F, out_illegal 0.
  - Without macro: 0x0000_0000, out_illegal 1.
- Backpressure: stream 8 back-to-back SLL ops (data i, shamt i), with out_ready low for 3 cycles mid-stream.
  - in_ready low exactly while out_valid && !out_ready;
  - all 8 results correct, in order, none duplicated.
- Flush: 3 ops in flight, assert flush for 1 cycle together with a new in_valid.
  - out_valid 0 next cycle;
  - no result emerges for those 4 ops;
  - an op accepted the following cycle completes normally after 5 cycles.
- Reset mid-stream: rst low 1 cycle with 5 ops in flight, out_ready low.
  - next cycle out_valid 0, out_data 0, in_ready 1;
  - no stale result appears afterwards.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe -- pipelined barrel shifter with a valid/ready handshake.
//
// Each of the L = log2(N) stages shifts its operand by 2^k when shamt[k] is
// set. The result therefore appears L register stages after the input is
// accepted. The whole pipeline advances or holds as one unit. It stalls only
// while the final stage holds a result that the consumer has not accepted.
//
// Optional feature macro: SHIFT_PIPE_ROTATE_EN
//   defined   : op 11 rotates right by shamt; out_illegal is tied to 0.
//   undefined : no rotate logic is built. Op 11 yields out_data = 0 and
//               out_illegal = 1, with the same latency and handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   flush        drop every in-flight operation (the valid bits clear)
//   in_valid     an operation is presented
//   in_ready     the block takes the operation this cycle (= !stall)
//   in_data      operand [N-1:0]
//   in_shamt     shift amount [L-1:0], unsigned
//   in_op        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid    a result is present (registered)
//   out_ready    the consumer takes the result
//   out_data     result [N-1:0] (registered)
//   out_illegal  the result came from an unsupported op (registered)
module shift_pipe #(
   parameter int N = 32,
   parameter int L = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [L-1:0] in_shamt,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_illegal
);

   // One shift step of fixed distance sh, applied only when en is set.
   // For SRA, the data MSB at any stage still equals the original sign bit.
   function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d,
                                                input logic [1:0]   op,
                                                input logic         en,
                                                input int           sh);
      logic [N-1:0] r;
      r = d;
      if (en) begin
         case (op)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = $unsigned($signed(d) >>> sh);
`ifdef SHIFT_PIPE_ROTATE_EN
            default: r = (d >> sh) | (d << (N - sh));
`else
            default: r = d;
`endif
         endcase
      end
      return r;
   endfunction

   // Stage registers
   logic         valid_q [L];
   logic [N-1:0] data_q  [L];
   logic [1:0]   op_q    [L];
   logic [L-1:0] shamt_q [L];

   // Next-state values for each stage
   logic         valid_d [L];
   logic [N-1:0] data_d  [L];
   logic [1:0]   op_d    [L];
   logic [L-1:0] shamt_d [L];

   // What feeds each stage: the input port for stage 0, otherwise the
   // previous stage register
   logic         src_valid [L];
   logic [N-1:0] src_data  [L];
   logic [1:0]   src_op    [L];
   logic [L-1:0] src_shamt [L];

   logic unused_bits [L];
   logic unused_tail;
   logic stall;
   logic accept;

   assign stall     = valid_q[L-1] && !out_ready;
   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;
   assign out_valid = valid_q[L-1];
   assign out_data  = data_q[L-1];

   assign src_valid[0] = accept;
   assign src_op[0]    = in_op;
   assign src_shamt[0] = in_shamt;
`ifdef SHIFT_PIPE_ROTATE_EN
   assign src_data[0]  = in_data;
`else
   // An unsupported op enters as zero. Every later stage then passes zero
   // through, because a shifted zero is still zero.
   assign src_data[0]  = (in_op == 2'b11) ? '0 : in_data;
`endif

   genvar gi;
   generate
      for (gi = 1; gi < L; gi++) begin : g_link
         assign src_valid[gi] = valid_q[gi-1];
         assign src_data[gi]  = data_q[gi-1];
         assign src_op[gi]    = op_q[gi-1];
         assign src_shamt[gi] = shamt_q[gi-1];
      end

      for (gi = 0; gi < L; gi++) begin : g_stage
         localparam int SH = 1 << gi;
         assign valid_d[gi] = src_valid[gi];
         assign op_d[gi]    = src_op[gi];
         assign shamt_d[gi] = src_shamt[gi];
         assign data_d[gi]  = stage_shift(src_data[gi], src_op[gi],
                                          src_shamt[gi][gi], SH);
         // Shift-amount bits below and above position gi do not affect
         // this stage; they are only carried along the pipeline.
         assign unused_bits[gi] = ^src_shamt[gi];
      end
   endgenerate

   // The last stage's op and shamt have no stage after them to consume them
   assign unused_tail = ^{op_q[L-1], shamt_q[L-1]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < L; k++) begin
            valid_q[k] <= 1'b0;
            data_q[k]  <= '0;
            op_q[k]    <= '0;
            shamt_q[k] <= '0;
         end
      end else begin
         if (!stall) begin
            for (int k = 0; k < L; k++) begin
               valid_q[k] <= valid_d[k];
               data_q[k]  <= data_d[k];
               op_q[k]    <= op_d[k];
               shamt_q[k] <= shamt_d[k];
            end
         end
         // Flush overrides a stall. The output that was accepted in this
         // cycle has already been consumed, and it is simply cleared.
         if (flush) begin
            for (int k = 0; k < L; k++) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

`ifdef SHIFT_PIPE_ROTATE_EN
   assign out_illegal = 1'b0;
`else
   logic illegal_q;
   logic illegal_d;

   // Decoded as the op enters the final stage, so the output stays a flop
   assign illegal_d = (src_op[L-1] == 2'b11);

   always_ff @(posedge clk) begin
      if (!rst) begin
         illegal_q <= 1'b0;
      end else if (!stall) begin
         illegal_q <= illegal_d;
      end
   end

   assign out_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_illegal;

   int tests_run = 0;
   int tests_failed = 0;

   // Each entry is {nothing_expected_flag, illegal, data}
   logic [33:0] pend[$];
   logic [33:0] got[$];
   logic [33:0] exp_q[$];
   logic        last_acc;

   shift_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: the shift computed directly from the operation definitions
   function automatic logic [32:0] ref_model(input logic [31:0] d, input int s,
                                             input logic [1:0] op);
      logic signed [31:0] sd;
      logic [31:0] r;
      sd = d;
      case (op)
         2'd0: r = d << s;
         2'd1: r = d >> s;
         2'd2: r = sd >>> s;
         default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
            r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`else
            return {1'b1, 32'h0};
`endif
         end
      endcase
      return {1'b0, r};
   endfunction

   // Advances one clock cycle; it is called at a falling edge. It records
   // consumed outputs and maintains the in-flight model.
   task automatic tick();
      logic acc;
      #1;
      acc = in_valid && in_ready && rst;
      if (!rst) begin
         pend.delete();
      end else begin
         if (out_valid && out_ready) begin
            got.push_back({1'b0, out_illegal, out_data});
            if (pend.size() > 0) exp_q.push_back(pend.pop_front());
            else exp_q.push_back({1'b1, 33'h0});
         end
         if (flush) pend.delete();
         else if (acc) pend.push_back({1'b0, ref_model(in_data, int'(in_shamt), in_op)});
      end
      last_acc = acc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
      in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (last_acc) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 60 && (pend.size() > 0 || out_valid); k++) tick();
      tests_run++;
      if (pend.size() != 0 || out_valid) begin
         tests_failed++;
         $display("FAIL drain_timeout: pending=%0d out_valid=%0b required 0/0", pend.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++;
      if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      tests_run++;
      if (out_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_out_illegal: got %b want 0", out_illegal); end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      $display("[TB] reset: out_valid=%b out_data=%h in_ready=%b", out_valid, out_data, in_ready);
   endtask

   task automatic test_directed();
      logic [31:0] dd  [7] = '{32'h1, 32'h1, 32'h800000F0, 32'h800000F0, 32'h7FFFFFFF, 32'h800000F0, 32'hF1};
      logic [4:0]  ss  [7] = '{5'd31, 5'd0, 5'd4, 5'd4, 5'd31, 5'd0, 5'd4};
      logic [1:0]  oo  [7] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
      logic [33:0] want[7];
      int base;
      int cnt;
      want[0] = {2'b00, 32'h80000000};
      want[1] = {2'b00, 32'h00000001};
      want[2] = {2'b00, 32'hF800000F};
      want[3] = {2'b00, 32'h0800000F};
      want[4] = {2'b00, 32'h00000000};
      want[5] = {2'b00, 32'h800000F0};
`ifdef SHIFT_PIPE_ROTATE_EN
      want[6] = {2'b00, 32'h1000000F};
`else
      want[6] = {2'b01, 32'h00000000};
`endif
      out_ready = 1'b1;
      base = got.size();
      issue(dd[0], ss[0], oo[0]);
      cnt = 1;
      while (!out_valid && cnt < 20) begin tick(); cnt++; end
      tests_run++;
      if (cnt != 5) begin tests_failed++; $display("FAIL latency: got %0d cycles want 5", cnt); end
      for (int i = 1; i < 7; i++) issue(dd[i], ss[i], oo[i]);
      drain();
      for (int i = 0; i < 7; i++) begin
         tests_run++;
         if (base + i >= got.size()) begin
            tests_failed++;
            $display("FAIL directed_%0d: no result, want %h", i, want[i]);
         end else begin
            $display("[TB] directed %0d: data=%h shamt=%0d op=%0d -> %h (want %h)", i, dd[i], ss[i], oo[i], got[base+i], want[i]);
            if (got[base+i] !== want[i]) begin
               tests_failed++;
               $display("FAIL directed_%0d: got %h want %h", i, got[base+i], want[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      int sent;
      logic want_rdy;
      base = got.size();
      sent = 0;
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 6 && c <= 8);
         in_valid = (sent < 8);
         in_data = 32'(sent); in_shamt = 5'(sent); in_op = 2'd0;
         #1;
         want_rdy = !(c >= 6 && c <= 8);
         tests_run++;
         if (in_ready !== want_rdy) begin
            tests_failed++;
            $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready, want_rdy);
         end
         tick();
         if (last_acc) sent++;
      end
      drain();
      tests_run++;
      if (got.size() - base != 8) begin
         tests_failed++;
         $display("FAIL bp_count: got %0d results want 8", got.size() - base);
      end
      for (int i = 0; i < 8 && base + i < got.size(); i++) begin
         logic [31:0] v;
         v = 32'(i);
         tests_run++;
         $display("[TB] bp %0d: %h (want %h)", i, got[base+i], {2'b00, v << i});
         if (got[base+i] !== {2'b00, v << i}) begin
            tests_failed++;
            $display("FAIL bp_result_%0d: got %h want %h", i, got[base+i], {2'b00, v << i});
         end
      end
   endtask

   task automatic test_flush();
      int base;
      int cnt;
      logic [33:0] want;
      out_ready = 1'b1;
      base = got.size();
      for (int i = 0; i < 3; i++) issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)));
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'd3; in_op = 2'd1;
      flush = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
      want = {1'b0, ref_model(32'hA5A5_0F0F, 7, 2'd2)};
      issue(32'hA5A5_0F0F, 5'd7, 2'd2);
      cnt = 1;
      while (!out_valid && cnt < 20) begin tick(); cnt++; end
      tests_run++;
      if (cnt != 5) begin tests_failed++; $display("FAIL flush_latency: got %0d want 5", cnt); end
      drain();
      tests_run++;
      if (got.size() - base != 1) begin
         tests_failed++;
         $display("FAIL flush_count: got %0d results want 1", got.size() - base);
      end else begin
         tests_run++;
         $display("[TB] flush: post-flush result %h (want %h)", got[base], want);
         if (got[base] !== want) begin
            tests_failed++;
            $display("FAIL flush_result: got %h want %h", got[base], want);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int base;
      base = got.size();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 2)));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      tests_run++;
      if (out_data !== 32'h0) begin tests_failed++; $display("FAIL midrst_out_data: got %h want 0", out_data); end
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
      out_ready = 1'b1;
      repeat (12) tick();
      tests_run++;
      $display("[TB] midstream reset: %0d stale results after reset", got.size() - base);
      if (got.size() != base) begin
         tests_failed++;
         $display("FAIL midrst_stale: got %0d results want 0", got.size() - base);
      end
   endtask

   task automatic test_random();
      int base;
      base = got.size();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_shamt  = 5'($urandom_range(0, 31));
         in_op     = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         tick();
      end
      flush = 1'b0;
      drain();
      for (int i = base; i < got.size(); i++) begin
         tests_run++;
         $display("[TB] random %0d: got %h want %h", i - base, got[i], exp_q[i]);
         if (got[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL random_%0d: got %h want %h", i - base, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_shamt = '0; in_op = '0; out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
